// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request, store/load stream and data memory signals of mem_access_unit

interface mem_access_unit_if;
  // request channel
  logic        reqValid;
  logic        reqReady;
  logic        reqStore;
  logic [4:0]  reqSlot;
  logic [1:0]  reqLen;
  // store beat channel
  logic [31:0] wrData;
  logic        wrValid;
  logic        wrReady;
  // load return stream
  logic [31:0] rdData;
  logic        rdValid;
  logic        rdLast;
  // completion
  logic        done;
  logic        error;
  // data memory port
  logic        memWriteEnable;
  logic [31:0] memAddress;
  logic [31:0] memDataOut;
  logic [31:0] memDataIn;

  // sequencer side
  modport slave (
    input  reqValid, reqStore, reqSlot, reqLen, wrData, wrValid, memDataIn,
    output reqReady, wrReady, rdData, rdValid, rdLast, done, error,
           memWriteEnable, memAddress, memDataOut
  );

  // datapath and memory side
  modport master (
    output reqValid, reqStore, reqSlot, reqLen, wrData, wrValid, memDataIn,
    input  reqReady, wrReady, rdData, rdValid, rdLast, done, error,
           memWriteEnable, memAddress, memDataOut
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - slot-addressed single/burst load/store sequencer for the data memory

module mem_access_unit #(
  parameter int SLOTS     = 17,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus
);

  localparam int         CNT_W      = $clog2(MAX_BURST);
  localparam logic [5:0] SLOT_LIMIT = 6'(SLOTS);

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    WRITE,
    READ,
    DRAIN,
    RESP
  } state_t;

  state_t           state;
  logic [5:0]       slot_q;    // slot of the next beat to issue
  logic [CNT_W-1:0] cnt_q;     // beats still to issue after the current one
  logic             s1_valid;  // address registered on the previous edge
  logic             s1_last;
  logic             s2_valid;  // memory has registered the read word
  logic             s2_last;

  logic [5:0]       req_end;
  logic             accept;
  logic             beat;

  // Logical slot to physical word address; slots 0..4 are 4 apart, 5 onwards
  // start at 0x12 and continue 4 apart.
  function automatic logic [31:0] slot_addr(input logic [5:0] slot);
    case (slot)
      6'd0:    slot_addr = 32'h00;
      6'd1:    slot_addr = 32'h04;
      6'd2:    slot_addr = 32'h08;
      6'd3:    slot_addr = 32'h0C;
      6'd4:    slot_addr = 32'h10;
      6'd5:    slot_addr = 32'h12;
      6'd6:    slot_addr = 32'h16;
      6'd7:    slot_addr = 32'h1A;
      6'd8:    slot_addr = 32'h1E;
      6'd9:    slot_addr = 32'h22;
      6'd10:   slot_addr = 32'h26;
      6'd11:   slot_addr = 32'h2A;
      6'd12:   slot_addr = 32'h2E;
      6'd13:   slot_addr = 32'h32;
      6'd14:   slot_addr = 32'h36;
      6'd15:   slot_addr = 32'h3A;
      6'd16:   slot_addr = 32'h3E;
      default: slot_addr = 32'h00;
    endcase
  endfunction

  // Request legality (last slot touched) and the two handshakes.
  always_comb begin
    req_end = {1'b0, bus.reqSlot} + 6'(bus.reqLen);
    accept  = bus.reqValid && bus.reqReady;
    beat    = (state == WRITE) && bus.wrValid && bus.wrReady;
  end

  // Sequencer FSM with registered outputs plus the two-stage read return pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      slot_q             <= 6'd0;
      cnt_q              <= '0;
      s1_valid           <= 1'b0;
      s1_last            <= 1'b0;
      s2_valid           <= 1'b0;
      s2_last            <= 1'b0;
      bus.reqReady       <= 1'b0;
      bus.wrReady        <= 1'b0;
      bus.rdData         <= 32'h0;
      bus.rdValid        <= 1'b0;
      bus.rdLast         <= 1'b0;
      bus.done           <= 1'b0;
      bus.error          <= 1'b0;
      bus.memWriteEnable <= 1'b1;
      bus.memAddress     <= 32'h0;
      bus.memDataOut     <= 32'h0;
    end else begin
      // pulses and the strobe default to inactive every cycle
      bus.reqReady       <= 1'b0;
      bus.done           <= 1'b0;
      bus.error          <= 1'b0;
      bus.memWriteEnable <= 1'b1;
      s1_valid           <= 1'b0;

      // read data comes back two edges after its address was registered
      s2_valid    <= s1_valid;
      s2_last     <= s1_last;
      bus.rdValid <= s2_valid;
      bus.rdLast  <= s2_valid && s2_last;
      if (s2_valid) begin
        bus.rdData <= bus.memDataIn;
      end

      case (state)
        IDLE: begin
          // ready is dropped on the accepting edge so only one request is taken
          bus.reqReady <= !accept;
          if (accept) begin
            cnt_q <= CNT_W'(bus.reqLen);
            if (req_end >= SLOT_LIMIT) begin
              slot_q <= {1'b0, bus.reqSlot};
              state  <= ERR;
            end else if (bus.reqStore) begin
              slot_q      <= {1'b0, bus.reqSlot};
              bus.wrReady <= 1'b1;
              state       <= WRITE;
            end else begin
              // beat 0 address goes out on the accepting edge itself
              bus.memAddress <= slot_addr({1'b0, bus.reqSlot});
              s1_valid       <= 1'b1;
              s1_last        <= (bus.reqLen == 2'd0);
              slot_q         <= {1'b0, bus.reqSlot} + 6'd1;
              state          <= (bus.reqLen == 2'd0) ? DRAIN : READ;
            end
          end
        end

        ERR: begin
          bus.done  <= 1'b1;
          bus.error <= 1'b1;
          state     <= IDLE;
        end

        WRITE: begin
          if (beat) begin
            bus.memAddress     <= slot_addr(slot_q);
            bus.memDataOut     <= bus.wrData;
            bus.memWriteEnable <= 1'b0;
            slot_q             <= slot_q + 6'd1;
            if (cnt_q == '0) begin
              bus.wrReady <= 1'b0;
              state       <= RESP;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end

        READ: begin
          bus.memAddress <= slot_addr(slot_q);
          s1_valid       <= 1'b1;
          s1_last        <= (cnt_q == CNT_W'(1));
          slot_q         <= slot_q + 6'd1;
          cnt_q          <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state <= DRAIN;
          end
        end

        DRAIN: begin
          // done coincides with the final rdValid
          if (s2_valid && s2_last) begin
            bus.done <= 1'b1;
            state    <= IDLE;
          end
        end

        RESP: begin
          bus.done <= 1'b1;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
